mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 6-stage pipeline: takes EX/MEM bundle, drives data_memory (address/read/write/data_bus_write),
//  captures load data, registers MEM/WB bundle for writeback. Loads take 2 cycles (upstream stalled 1), stores/ALU ops 1.
//  Sits between EX/MEM pipeline register and writeback; sole master of data_memory ports.
// PARAMETERS
//  DATA_W      16   data bus / register width
//  ADDR_W      16   memory address width
//  REG_ADDR_W  3    destination register index width
//  MEM_SIZE    512  words implemented in data_memory (used by bounds check)
// PORTS
//  clock           in   1           single clock, all state on rising edge
//  reset           in   1           asynchronous, active-low; clears all state immediately
//  ex_valid        in   1           EX/MEM bundle valid
//  ex_alu_result   in   DATA_W      ALU result / effective address
//  ex_store_data   in   DATA_W      store operand
//  ex_mem_read     in   1           instruction is a load
//  ex_mem_write    in   1           instruction is a store
//  ex_reg_write    in   1           instruction writes a register
//  ex_rd           in   REG_ADDR_W  destination register
//  mem_stall       out  1           hold EX/MEM and earlier stages this cycle
//  address         out  ADDR_W      to data_memory
//  read            out  1           to data_memory
//  write           out  1           to data_memory
//  data_bus_write  out  DATA_W      to data_memory
//  data_bus_read   in   DATA_W      from data_memory (Z when idle)
//  wb_valid        out  1           MEM/WB bundle valid (registered)
//  wb_reg_write    out  1           registered
//  wb_rd           out  REG_ADDR_W  registered
//  wb_data         out  DATA_W      load data or ALU result (registered)
//  mem_fault       out  1           sticky fault flag, cleared only by reset
// BEHAVIOUR
//  - Reset (reset==0): state=IDLE; wb_valid/wb_reg_write/wb_rd/wb_data/mem_fault=0; read/write/mem_stall forced 0
//    combinationally, incl. mid-load (load abandoned, nothing written back).
//  - FSM states: IDLE, LOAD_CAP. address=ex_alu_result, data_bus_write=ex_store_data at all times.
//  - IDLE, ex_valid & load: read=1, mem_stall=1, next LOAD_CAP; wb_valid<=0 (bubble).
//  - LOAD_CAP: read=1, mem_stall=0; at edge wb_data<=data_bus_read, wb_rd/wb_reg_write from ex, wb_valid<=1 -> IDLE.
//  - IDLE, ex_valid & store: write=1 for exactly this cycle, no stall; wb_valid<=1, wb_reg_write<=0.
//  - IDLE, ex_valid & neither: wb_data<=ex_alu_result, wb_* from ex, wb_valid<=1.
//  - ex_mem_read & ex_mem_write both 1: illegal; neither strobe asserted, mem_fault<=1, wb_valid<=1, wb_reg_write<=0.
//  - ex_valid==0 in IDLE: read=write=0, wb_valid<=0; wb_data/wb_rd hold.
//  - read and write never both 1. Write strobe never asserted in LOAD_CAP.
//  - Back-to-back loads: 2 cycles each, one bubble each; load followed by store: store issues in cycle after LOAD_CAP.
//  - Address is passed unmodified (no wrap) unless bounds check compiled in.
// CONFIGURATION
//  MEM_ACCESS_BOUNDS_CHECK_EN defined: a load/store with ex_alu_result >= MEM_SIZE asserts neither strobe,
//    sets mem_fault, retires with wb_reg_write=0 (load never enters LOAD_CAP, no stall).
//  Not defined: no range check; out-of-range address goes to data_memory as-is; mem_fault only from read&write case.
// STRUCTURE
//  Shared package mem_stage_pkg: state encoding (IDLE=1'b0, LOAD_CAP=1'b1), DATA_W/ADDR_W/REG_ADDR_W defaults.
//  One sub-module: mem_addr_check (combinational, ADDR_W/MEM_SIZE params, out: in_range), instantiated only under
//  MEM_ACCESS_BOUNDS_CHECK_EN. FSM, strobes and MEM/WB register stay in mem_access_stage.
// TESTING
//  1 Reset low 3 cycles, release -> all wb_*, mem_fault, read, write, mem_stall = 0.
//  2 ALU op alu=16'h00A5 rd=3 reg_write=1 -> next cycle wb_valid=1 wb_data=00A5 wb_rd=3, read=write=0 throughout.
//  3 Store addr=2 data=16'h1234 -> write=1 one cycle, address=2, data_bus_write=1234; then load addr=2 ->
//    mem_stall=1 one cycle, read=1 two cycles, wb_data=1234 wb_rd as given.
//  4 Load addr=5, reset pulled low during LOAD_CAP -> read drops immediately, wb_valid=0, state IDLE after release.
//  5 ex_mem_read=ex_mem_write=1 -> no strobe, mem_fault=1 and stays 1 until reset.
//  6 (with MEM_ACCESS_BOUNDS_CHECK_EN) store addr=16'd512 -> write stays 0, mem_fault=1; addr=16'd511 -> write=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding and
// default widths for the data path, memory address and register index.
package mem_stage_pkg;

  localparam int MEM_DATA_W     = 16;
  localparam int MEM_ADDR_W     = 16;
  localparam int MEM_REG_ADDR_W = 3;

  // IDLE accepts a new EX/MEM bundle; LOAD_CAP is the second cycle of a load,
  // in which the data_memory read data is captured into MEM/WB.
  typedef enum logic {
    IDLE     = 1'b0,
    LOAD_CAP = 1'b1
  } mem_state_e;

endpackage : mem_stage_pkg

// File: rtl/mem_addr_check.sv
// Combinational range check of a data_memory address against the number of
// implemented words. Only built when MEM_ACCESS_BOUNDS_CHECK_EN is defined,
// because the MEM stage instantiates it only in that configuration.
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
module mem_addr_check #(
  parameter int ADDR_W   = 16,
  parameter int MEM_SIZE = 512
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  // Address is legal when it indexes an implemented word.
  assign in_range = (32'(addr) < 32'(MEM_SIZE));

endmodule : mem_addr_check
`endif

// File: rtl/mem_access_stage.sv
// MEM stage of the 6-stage pipeline. Drives data_memory from the EX/MEM
// bundle, captures load data one cycle after issuing the read (stalling the
// upstream stages for that cycle), and registers the MEM/WB bundle.
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to reject loads/stores
// whose address is at or beyond MEM_SIZE (raises mem_fault instead).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int REG_ADDR_W = MEM_REG_ADDR_W,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_stall,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     data_bus_write,
  input  logic [DATA_W-1:0]     data_bus_read,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  mem_fault
);

  mem_state_e            state_q, state_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  mem_fault_q, mem_fault_d;

  logic is_load, is_store, is_illegal, is_mem_op;
  logic in_range, start_load, bad_access, in_idle;

  // Address and store data go straight through to data_memory.
  assign address        = ADDR_W'(ex_alu_result);
  assign data_bus_write = ex_store_data;

  assign is_load    = ex_mem_read & ~ex_mem_write;
  assign is_store   = ex_mem_write & ~ex_mem_read;
  assign is_illegal = ex_mem_read & ex_mem_write;
  assign is_mem_op  = ex_mem_read | ex_mem_write;
  assign in_idle    = (state_q == IDLE);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  mem_addr_check #(
    .ADDR_W   (ADDR_W),
    .MEM_SIZE (MEM_SIZE)
  ) u_addr_check (
    .addr     (address),
    .in_range (in_range)
  );
`else
  // Without the range check every address is treated as in range; this is
  // true for any meaningful (non-zero) memory size.
  assign in_range = (MEM_SIZE > 0);
`endif

  assign start_load = in_idle & ex_valid & is_load & in_range;
  assign bad_access = in_idle & ex_valid & (is_illegal | (is_mem_op & ~in_range));

  // State register: loads occupy IDLE (issue) then LOAD_CAP (capture).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_load) state_d = LOAD_CAP;
      LOAD_CAP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Memory strobes and stall; all forced low while reset is asserted, which
  // also abandons an in-flight load immediately.
  always_comb begin
    read      = reset & (start_load | (state_q == LOAD_CAP));
    write     = reset & in_idle & ex_valid & is_store & in_range;
    mem_stall = reset & start_load;
  end

  // MEM/WB bundle and sticky fault: next values.
  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    mem_fault_d    = mem_fault_q | bad_access;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (bad_access) begin
            // Illegal or out-of-range access retires without a register write.
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = ex_rd;
          end else if (is_load) begin
            // Bubble while the read is in flight.
            wb_valid_d = 1'b0;
          end else if (is_store) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = ex_rd;
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_reg_write;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_alu_result;
          end
        end
      end
      LOAD_CAP: begin
        // EX/MEM is held by the stall, so ex_* still describe this load.
        wb_valid_d     = 1'b1;
        wb_reg_write_d = ex_reg_write;
        wb_rd_d        = ex_rd;
        wb_data_d      = data_bus_read;
      end
      default: ;
    endcase
  end

  // MEM/WB register and fault flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      mem_fault_q    <= 1'b0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      mem_fault_q    <= mem_fault_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_fault    = mem_fault_q;

endmodule : mem_access_stage
